system_top_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one signed 16×16 multiplier core among `N_REQ` requesters in the WLAN synchronization datapath (correlator, CFO and energy stages). It provides per-requester valid/ready operand ports and a single tagged, back-pressurable result port. It owns the operand/pipeline registers around the combinational multiplier core, so one multiplier instance serves all requesters at one product per cycle.

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_rr_arbiter.sv | 57 +++++
 rtl/system_top_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_system_top_mul_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared widths, pipeline-stage record and round-robin pointer helper for the
// multiplier arbiter.
package mul_arb_pkg;

  localparam int OPERAND_W = 16;
  localparam int PRODUCT_W = 30;
  // Stage records carry a generously sized id; each instance uses the low ID_W bits.
  localparam int ID_MAX_W  = 8;

  typedef struct packed {
    logic                 valid;
    logic [ID_MAX_W-1:0]  id;
    logic [PRODUCT_W-1:0] data;
  } mul_stage_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Round-robin grant search starting at a rotating pointer; the pointer moves
// just past the winner on every grant.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic             i_block,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_idx,
  output logic             o_grant_valid
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_grant_idx;
  logic            w_found;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    if (i_block) begin
      w_found = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign o_grant[gi] = w_found && (w_grant_idx == ID_W'(gi));
    end
  endgenerate

  assign o_grant_idx   = w_grant_idx;
  assign o_grant_valid = w_found;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= ID_W'(rr_next(int'(w_grant_idx), N_REQ));
    end
  end

endmodule

// File: rtl/system_top_mul_arbiter.sv
// One shared signed 16x16 multiplier time-multiplexed among N_REQ requesters,
// with a tagged, back-pressurable, in-order result port.
module system_top_mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*OPERAND_W-1:0] req_a,
  input  logic [N_REQ*OPERAND_W-1:0] req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [PRODUCT_W-1:0]       res_data,
  output logic                       busy
);

  logic                        w_stall;
  logic [N_REQ-1:0]            w_grant;
  logic [ID_W-1:0]             w_grant_idx;
  logic                        w_grant_valid;
  logic signed [OPERAND_W-1:0] w_sel_a;
  logic signed [OPERAND_W-1:0] w_sel_b;
  logic signed [PRODUCT_W-1:0] w_product;
  logic                        w_busy;

  logic signed [OPERAND_W-1:0] r_s0_a;
  logic signed [OPERAND_W-1:0] r_s0_b;
  logic [ID_W-1:0]             r_s0_id;
  logic                        r_s0_valid;
  mul_stage_t                  r_res [MUL_LAT];

  assign w_stall = r_res[MUL_LAT-1].valid & ~res_ready;

  // Reset also blocks grants so nothing is accepted while the pipe is being flushed.
  mul_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_clk         (ap_clk),
    .i_srst        (ap_rst),
    .i_req_valid   (req_valid),
    .i_block       (w_stall | ap_rst),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*OPERAND_W +: OPERAND_W];
        w_sel_b = req_b[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s0_valid <= 1'b0;
      r_s0_id    <= '0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
    end else if (!w_stall) begin
      r_s0_valid <= w_grant_valid;
      r_s0_id    <= w_grant_idx;
      r_s0_a     <= w_sel_a;
      r_s0_b     <= w_sel_b;
    end
  end

  // Full-width signed product, then keep the low 30 bits (modular wrap).
  assign w_product = PRODUCT_W'((2*OPERAND_W)'(r_s0_a) * (2*OPERAND_W)'(r_s0_b));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_res[0] <= '0;
    end else if (!w_stall) begin
      r_res[0].valid <= r_s0_valid;
      r_res[0].id    <= ID_MAX_W'(r_s0_id);
      r_res[0].data  <= w_product;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < MUL_LAT; gi++) begin : g_res_stage
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          r_res[gi] <= '0;
        end else if (!w_stall) begin
          r_res[gi] <= r_res[gi-1];
        end
      end
    end
    if (ID_W < ID_MAX_W) begin : g_id_pad
      logic w_unused_id;
      assign w_unused_id = |r_res[MUL_LAT-1].id[ID_MAX_W-1:ID_W];
    end
  endgenerate

  always_comb begin
    w_busy = r_s0_valid;
    for (int i = 0; i < MUL_LAT; i++) begin
      w_busy = w_busy | r_res[i].valid;
    end
  end

  assign res_valid = r_res[MUL_LAT-1].valid;
  assign res_id    = r_res[MUL_LAT-1].id[ID_W-1:0];
  assign res_data  = r_res[MUL_LAT-1].data;
  assign busy      = w_busy;

endmodule

// File: tb/tb_system_top_mul_arbiter.sv
// Directed bench for the shared-multiplier arbiter: single request, contention,
// back-pressure, wrap arithmetic, pointer wrap and mid-flight reset.
module tb_system_top_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [29:0] res_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int exp_p [4] = '{-33, -66, -99, -132};

  system_top_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(1)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[16*i +: 16] = 16'(a);
    req_b[16*i +: 16] = 16'(b);
  endtask

  task automatic check_res(input string tag, input int id, input int data);
    check({tag, ".valid"}, int'(res_valid), 1);
    check({tag, ".id"}, int'(res_id), id);
    check({tag, ".data"}, $signed(res_data), data);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    step();
    step();
    ap_rst = 1'b0;
    #1;
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #1;
    do_reset();
    check("rst.res_valid", int'(res_valid), 0);
    check("rst.res_id", int'(res_id), 0);
    check("rst.res_data", $signed(res_data), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.req_ready", int'(req_ready), 0);

    // Single request from requester 2: 300 * -7
    set_op(2, 300, -7);
    req_valid = 4'b0100;
    #1;
    check("single.ready", int'(req_ready), 4'b0100);
    step();
    req_valid = '0;
    #1;
    check("single.c1.res_valid", int'(res_valid), 0);
    check("single.c1.busy", int'(busy), 1);
    step();
    check_res("single.c2", 2, -2100);
    step();
    check("single.drain.res_valid", int'(res_valid), 0);
    check("single.drain.busy", int'(busy), 0);

    // Full contention from pointer 0
    do_reset();
    set_op(0, 11, -3);
    set_op(1, 22, -3);
    set_op(2, 33, -3);
    set_op(3, 44, -3);
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check($sformatf("cont.ready%0d", k), int'(req_ready), 1 << (k % 4));
      if (k >= 2 && k < 10) check_res($sformatf("cont.res%0d", k - 2), (k - 2) % 4, exp_p[(k - 2) % 4]);
      else check($sformatf("cont.idle%0d", k), int'(res_valid), 0);
      step();
    end

    // Back-pressure: requester 1 (-5*7) then requester 3, stall 5 cycles
    set_op(1, -5, 7);
    req_valid = 4'b0010;
    #1;
    check("bp.ready1", int'(req_ready), 4'b0010);
    step();
    req_valid = 4'b1000;
    #1;
    check("bp.ready3", int'(req_ready), 4'b1000);
    step();
    req_valid = 4'b1111;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp.stall%0d.ready", k), int'(req_ready), 0);
      check_res($sformatf("bp.stall%0d", k), 1, -35);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check_res("bp.release", 1, -35);
    step();
    check_res("bp.next", 3, -132);
    step();
    check("bp.done.res_valid", int'(res_valid), 0);
    check("bp.done.busy", int'(busy), 0);

    // Wrap arithmetic on requester 0 (pointer is 0 here)
    set_op(0, -32768, -32768);
    req_valid = 4'b0001;
    #1;
    check("wrap.ready_a", int'(req_ready), 4'b0001);
    step();
    set_op(0, 16384, 16384);
    #1;
    check("wrap.ready_b", int'(req_ready), 4'b0001);
    step();
    req_valid = '0;
    #1;
    check_res("wrap.min", 0, 0);
    step();
    check_res("wrap.2p28", 0, 268435456);
    step();

    // Pointer wrap: grant requester 2 to move ptr to 3, then 3 and 1 contend
    set_op(0, 11, -3);
    req_valid = 4'b0100;
    #1;
    check("pwrap.pre", int'(req_ready), 4'b0100);
    step();
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1010;
      #1;
      check($sformatf("pwrap.grant%0d", k), int'(req_ready), (k % 2 == 0) ? 4'b1000 : 4'b0010);
      step();
    end
    req_valid = '0;
    step();
    step();
    check("pwrap.done.busy", int'(busy), 0);

    // Reset with two products in flight (ptr is 2 here)
    req_valid = 4'b1111;
    #1;
    check("mid.accept_a", int'(req_ready), 4'b0100);
    step();
    check("mid.accept_b", int'(req_ready), 4'b1000);
    step();
    res_ready = 1'b0;
    ap_rst    = 1'b1;
    #1;
    check("mid.rst.ready", int'(req_ready), 0);
    step();
    ap_rst    = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check("mid.after.res_valid", int'(res_valid), 0);
    check("mid.after.busy", int'(busy), 0);
    check("mid.after.res_data", $signed(res_data), 0);
    step();
    check("mid.after2.res_valid", int'(res_valid), 0);
    req_valid = 4'b1111;
    #1;
    check("mid.first_grant", int'(req_ready), 4'b0001);
    step();
    req_valid = '0;
    step();
    check_res("mid.res", 0, -33);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
